// File: rtl/vx_barrier_ctrl_if.sv
// rtl/vx_barrier_ctrl_if.sv - barrier op, warp mask and global barrier handshake bundle
interface vx_barrier_ctrl_if #(
  parameter int NUM_WARPS    = 4,
  parameter int NUM_BARRIERS = 4,
  parameter int GSIZE_WIDTH  = 2
);
  localparam int NW_WIDTH   = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int NB_WIDTH   = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1;
  localparam int SIZE_WIDTH = (NW_WIDTH > GSIZE_WIDTH) ? NW_WIDTH : GSIZE_WIDTH;

  logic                   bar_valid;
  logic                   bar_ready;
  logic [NW_WIDTH-1:0]    bar_wid;
  logic [NB_WIDTH-1:0]    bar_id;
  logic                   bar_is_global;
  logic [SIZE_WIDTH-1:0]  bar_size_m1;
  logic                   bar_is_noop;
  logic [NUM_WARPS-1:0]   active_wmask;
  logic [NUM_WARPS-1:0]   stall_wmask;
  logic                   gbar_req_valid;
  logic                   gbar_req_ready;
  logic [NB_WIDTH-1:0]    gbar_req_id;
  logic [GSIZE_WIDTH-1:0] gbar_req_size_m1;
  logic                   gbar_rsp_valid;
  logic [NB_WIDTH-1:0]    gbar_rsp_id;

  modport slave (
    input  bar_valid, bar_wid, bar_id, bar_is_global, bar_size_m1, bar_is_noop,
    input  active_wmask, gbar_req_ready, gbar_rsp_valid, gbar_rsp_id,
    output bar_ready, stall_wmask, gbar_req_valid, gbar_req_id, gbar_req_size_m1
  );

  modport master (
    output bar_valid, bar_wid, bar_id, bar_is_global, bar_size_m1, bar_is_noop,
    output active_wmask, gbar_req_ready, gbar_rsp_valid, gbar_rsp_id,
    input  bar_ready, stall_wmask, gbar_req_valid, gbar_req_id, gbar_req_size_m1
  );
endinterface

// File: rtl/vx_barrier_ctrl.sv
// rtl/vx_barrier_ctrl.sv - per-core local/global barrier arrival counting and warp stall mask
module vx_barrier_ctrl #(
  parameter int NUM_WARPS    = 4,
  parameter int NUM_BARRIERS = 4,
  parameter int GSIZE_WIDTH  = 2
) (
  input logic             clk,
  input logic             reset,
  vx_barrier_ctrl_if.slave bus
);
  localparam int NW_WIDTH   = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int NB_WIDTH   = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1;
  localparam int SIZE_WIDTH = (NW_WIDTH > GSIZE_WIDTH) ? NW_WIDTH : GSIZE_WIDTH;
  localparam int PC_WIDTH   = NW_WIDTH + 1;

  logic [NW_WIDTH-1:0]    lcnt_q  [NUM_BARRIERS];
  logic [NW_WIDTH-1:0]    lcnt_d  [NUM_BARRIERS];
  logic [NUM_WARPS-1:0]   lwait_q [NUM_BARRIERS];
  logic [NUM_WARPS-1:0]   lwait_d [NUM_BARRIERS];
  logic [NW_WIDTH-1:0]    gcnt_q  [NUM_BARRIERS];
  logic [NW_WIDTH-1:0]    gcnt_d  [NUM_BARRIERS];
  logic [NUM_WARPS-1:0]   gwait_q [NUM_BARRIERS];
  logic [NUM_WARPS-1:0]   gwait_d [NUM_BARRIERS];
  logic [NUM_WARPS-1:0]   stall_q, stall_d;
  logic                   req_valid_q, req_valid_d;
  logic [NB_WIDTH-1:0]    req_id_q, req_id_d;
  logic [GSIZE_WIDTH-1:0] req_size_q, req_size_d;

  logic [PC_WIDTH-1:0]    active_cnt;
  logic [NUM_WARPS-1:0]   new_set, lrel_mask, grel_mask;
  logic                   op_fire;

  assign op_fire = bus.bar_valid && bus.bar_ready && !bus.bar_is_noop;

  // An empty active mask still lets a lone global arrival complete.
  always_comb begin
    active_cnt = '0;
    for (int i = 0; i < NUM_WARPS; i++) active_cnt = active_cnt + PC_WIDTH'(bus.active_wmask[i]);
    if (active_cnt == '0) active_cnt = PC_WIDTH'(1);
  end

  always_comb begin
    lcnt_d      = lcnt_q;
    lwait_d     = lwait_q;
    gcnt_d      = gcnt_q;
    gwait_d     = gwait_q;
    new_set     = '0;
    lrel_mask   = '0;
    grel_mask   = '0;
    req_valid_d = req_valid_q;
    req_id_d    = req_id_q;
    req_size_d  = req_size_q;

    if (req_valid_q && bus.gbar_req_ready) req_valid_d = 1'b0;

    // Response clears before the arrival below so a same-id arrival survives.
    if (bus.gbar_rsp_valid) begin
      grel_mask = gwait_q[bus.gbar_rsp_id];
      gwait_d[bus.gbar_rsp_id] = '0;
    end

    if (op_fire && !bus.bar_is_global) begin
      if (SIZE_WIDTH'(lcnt_q[bus.bar_id]) == bus.bar_size_m1) begin
        lrel_mask = lwait_q[bus.bar_id];
        lcnt_d[bus.bar_id]  = '0;
        lwait_d[bus.bar_id] = '0;
      end else begin
        lcnt_d[bus.bar_id] = NW_WIDTH'(lcnt_q[bus.bar_id] + 1'b1);
        lwait_d[bus.bar_id][bus.bar_wid] = 1'b1;
        new_set[bus.bar_wid] = 1'b1;
      end
    end

    if (op_fire && bus.bar_is_global) begin
      gwait_d[bus.bar_id][bus.bar_wid] = 1'b1;
      new_set[bus.bar_wid] = 1'b1;
      if ({1'b0, gcnt_q[bus.bar_id]} == active_cnt - 1'b1) begin
        gcnt_d[bus.bar_id] = '0;
        req_valid_d = 1'b1;
        req_id_d    = bus.bar_id;
        req_size_d  = bus.bar_size_m1[GSIZE_WIDTH-1:0];
      end else begin
        gcnt_d[bus.bar_id] = NW_WIDTH'(gcnt_q[bus.bar_id] + 1'b1);
      end
    end

    stall_d = (stall_q | new_set) & ~(lrel_mask | grel_mask);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < NUM_BARRIERS; b++) begin
        lcnt_q[b]  <= '0;
        lwait_q[b] <= '0;
        gcnt_q[b]  <= '0;
        gwait_q[b] <= '0;
      end
      stall_q     <= '0;
      req_valid_q <= 1'b0;
      req_id_q    <= '0;
      req_size_q  <= '0;
    end else begin
      lcnt_q      <= lcnt_d;
      lwait_q     <= lwait_d;
      gcnt_q      <= gcnt_d;
      gwait_q     <= gwait_d;
      stall_q     <= stall_d;
      req_valid_q <= req_valid_d;
      req_id_q    <= req_id_d;
      req_size_q  <= req_size_d;
    end
  end

  assign bus.bar_ready        = !req_valid_q;
  assign bus.stall_wmask      = stall_q;
  assign bus.gbar_req_valid   = req_valid_q;
  assign bus.gbar_req_id      = req_id_q;
  assign bus.gbar_req_size_m1 = req_size_q;

  always @(posedge clk) begin
    if (!reset && bus.bar_valid && bus.bar_ready)
      assert (!stall_q[bus.bar_wid]);
  end
endmodule
